// File: rtl/alu_op_sequencer.sv
// Sequences one 6502 ALU-class op: latch request, drive ALU operator flags for ALU_LATENCY cycles,
// capture result and flags into a response. Define ALU_SEQ_BACKTOBACK_EN to accept a new op in DONE.
module alu_op_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [3:0] OP,
  input  logic [7:0] OPA,
  input  logic [7:0] OPB,
  input  logic       C_IN,
  input  logic       D_IN,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic       SUMS,
  output logic       ANDS,
  output logic       ORS,
  output logic       EORS,
  output logic       SRS,
  output logic       DEC_En,
  output logic       ALU_Cin,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_OF,
  input  logic       ALU_Cout,
  input  logic       ALU_HCout,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [7:0] RES_DATA,
  output logic [3:0] RES_FLAGS,
  output logic [3:0] RES_FMASK
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADC = 4'd0, OP_SBC = 4'd1, OP_AND = 4'd2, OP_ORA = 4'd3, OP_EOR = 4'd4, OP_LSR = 4'd5,
    OP_ROR = 4'd6, OP_ASL = 4'd7, OP_ROL = 4'd8, OP_CMP = 4'd9, OP_BIT = 4'd10
  } op_t;

  localparam logic [1:0] CNT_INIT = 2'(ALU_LATENCY - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [7:0] opa_q, opa_d, opb_q, opb_d;
  logic       c_q, c_d, d_q, d_d;
  logic [7:0] res_data_q, res_data_d;
  logic [3:0] res_flags_q, res_flags_d, res_fmask_q, res_fmask_d;
  logic       latch, capture, exec;

  // half carry is not needed by any op this block sequences
  logic unused_hcout;
  assign unused_hcout = ALU_HCout;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      c_q         <= 1'b0;
      d_q         <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_fmask_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      c_q         <= c_d;
      d_q         <= d_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_fmask_q <= res_fmask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: if (REQ_VALID) begin
        latch   = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_q == 2'd0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: if (RES_READY) begin
`ifdef ALU_SEQ_BACKTOBACK_EN
        if (REQ_VALID) begin
          latch   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_SEQ_BACKTOBACK_EN
  assign REQ_READY = (state_q == S_IDLE) || (state_q == S_DONE && RES_READY);
`else
  assign REQ_READY = (state_q == S_IDLE);
`endif
  assign RES_VALID = (state_q == S_DONE);
  assign exec      = (state_q == S_EXEC);

  assign op_d  = latch ? OP   : op_q;
  assign opa_d = latch ? OPA  : opa_q;
  assign opb_d = latch ? OPB  : opb_q;
  assign c_d   = latch ? C_IN : c_q;
  assign d_d   = latch ? D_IN : d_q;

  // operator decode from latched op; gated to zero outside EXEC
  logic [4:0] fsel;
  logic       dec, cin;
  logic [7:0] a_drv, b_drv;
  always_comb begin
    fsel  = '0;
    dec   = 1'b0;
    cin   = 1'b0;
    a_drv = opa_q;
    b_drv = opb_q;
    case (op_q)
      OP_ADC: begin fsel = 5'b10000; dec = d_q; cin = c_q; end
      OP_SBC: begin
        fsel  = 5'b10000; dec = d_q; cin = c_q;
        b_drv = d_q ? {4'h9 - opb_q[7:4], 4'h9 - opb_q[3:0]} : ~opb_q;
      end
      OP_AND, OP_BIT: fsel = 5'b01000;
      OP_ORA:         fsel = 5'b00100;
      OP_EOR:         fsel = 5'b00010;
      OP_LSR, OP_ROR: begin fsel = 5'b00001; b_drv = 8'h01; end
      OP_ASL:         begin fsel = 5'b10000; b_drv = opa_q; end
      OP_ROL:         begin fsel = 5'b10000; b_drv = opa_q; cin = c_q; end
      OP_CMP:         begin fsel = 5'b10000; b_drv = ~opb_q; cin = 1'b1; end
      default: begin a_drv = '0; b_drv = '0; end
    endcase
  end

  assign {SUMS, ANDS, ORS, EORS, SRS} = exec ? fsel : 5'b0;
  assign DEC_En  = exec & dec;
  assign ALU_Cin = exec & cin;
  assign ALU_A   = exec ? a_drv : 8'h00;
  assign ALU_B   = exec ? b_drv : 8'h00;

  // response formation from the sampled ALU outputs
  logic [7:0] rd, nz_src;
  logic       fn, fv, fz, fc;
  logic [3:0] fmask;
  always_comb begin
    rd     = ALU_RESULT;
    nz_src = ALU_RESULT;
    fv     = ALU_OF;
    fc     = ALU_Cout;
    fmask  = 4'b0000;
    case (op_q)
      OP_ADC, OP_SBC:         fmask = 4'b1111;
      OP_AND, OP_ORA, OP_EOR: fmask = 4'b1010;
      OP_LSR: begin fc = opa_q[0]; fmask = 4'b1011; end
      OP_ROR: begin
        rd     = {c_q, ALU_RESULT[6:0]};
        nz_src = rd;
        fc     = opa_q[0];
        fmask  = 4'b1011;
      end
      OP_ASL, OP_ROL: fmask = 4'b1011;
      OP_CMP: begin rd = opa_q; fmask = 4'b1011; end
      OP_BIT: begin rd = opa_q; fv = opb_q[6]; fmask = 4'b1110; end
      default: begin rd = '0; nz_src = '0; end
    endcase
    fn = (op_q == OP_BIT) ? opb_q[7] : nz_src[7];
    fz = (nz_src == 8'h00);
  end

  assign res_data_d  = capture ? rd : res_data_q;
  assign res_flags_d = capture ? ({fn, fv, fz, fc} & fmask) : res_flags_q;
  assign res_fmask_d = capture ? fmask : res_fmask_q;

  assign RES_DATA  = res_data_q;
  assign RES_FLAGS = res_flags_q;
  assign RES_FMASK = res_fmask_q;
endmodule
